// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the uart_rx_vote receiver.
// UART_RX_PARITY_EN adds the PARITY state to the state encoding.
package uart_rx_pkg;

  localparam int DATA_BITS   = 8;
  localparam int SYNC_STAGES = 2;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    WAIT_IDLE, IDLE, START, DATA, PARITY, STOP
  } state_e;
`else
  typedef enum logic [2:0] {
    WAIT_IDLE, IDLE, START, DATA, STOP
  } state_e;
`endif

  function automatic int clks_per_bit(input int freq, input int baud);
    return (freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_vote_sync.sv
// RX pin synchroniser plus 3-sample history with majority vote.
// Framing-agnostic; resets to an idle-high line.
module rx_sync_vote
  import uart_rx_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic synced_o,
  output logic vote_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [2:0]             hist_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      hist_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      hist_q <= {hist_q[1:0], sync_q[SYNC_STAGES-1]};
    end
  end

  assign synced_o = sync_q[SYNC_STAGES-1];
  assign vote_o   = (hist_q[0] & hist_q[1]) |
                    (hist_q[0] & hist_q[2]) |
                    (hist_q[1] & hist_q[2]);

endmodule

// File: rtl/uart_rx_vote.sv
// 8N1 UART receiver with mid-bit majority voting and break recovery.
// Define UART_RX_PARITY_EN for a parity bit (sense set by PARITY_ODD).
module uart_rx_vote
  import uart_rx_pkg::*;
#(
  parameter int CLOCK_FREQ = 12_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       framing_error,
  output logic       parity_error,
  output logic       busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] EVAL = CW'(MID + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 8 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_vote: CLKS_PER_BIT < 8 or PARITY_ODD not 0/1");
  end

  logic synced, vote, eval;

  rx_sync_vote u_sync (
    .clk_i    (clk),
    .rst_i    (rst),
    .rx_i     (rx),
    .synced_o (synced),
    .vote_o   (vote)
  );

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   dv_q, dv_d;
  logic                   fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
  logic                   perr_q, perr_d;
  logic                   pe_q, pe_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign eval = (cnt_q == EVAL);

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
    pe_d    = 1'b0;
`endif
    unique case (state_q)
      WAIT_IDLE: begin
        if (!synced) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (!synced) state_d = START;
      end
      START: begin
        if (eval) begin
          if (vote) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
`ifdef UART_RX_PARITY_EN
            perr_d  = 1'b0;
`endif
          end
        end
      end
      DATA: begin
        if (eval) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (eval) begin
          perr_d  = (^shift_q ^ 1'(PARITY_ODD)) != vote;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (eval) begin
          if (vote) begin
`ifdef UART_RX_PARITY_EN
            if (perr_q) begin
              pe_d = 1'b1;
            end else begin
              dv_d   = 1'b1;
              data_d = shift_q;
            end
`else
            dv_d   = 1'b1;
            data_d = shift_q;
`endif
            state_d = IDLE;
          end else begin
            // Low stop bit is treated as a break: wait for a full idle bit.
            fe_d    = 1'b1;
`ifdef UART_RX_PARITY_EN
            pe_d    = perr_q;
`endif
            cnt_d   = '0;
            state_d = WAIT_IDLE;
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign data          = data_q;
  assign data_valid    = dv_q;
  assign framing_error = fe_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = pe_q;
`else
  assign parity_error  = 1'b0;
`endif
  assign busy = (state_q != WAIT_IDLE) && (state_q != IDLE);

endmodule
